alu_exec_ctrl: RTL
==================

Name: alu_exec_ctrl

Overview:
Execute-stage sequencer directly upstream of the multicycle ALU. It accepts one decoded MIPS instruction word plus register operands and derives the ALU opcode and operands. It drives the ALU enable until done, then captures result, HI/LO, overflow and zero, and presents one writeback/branch record to the register-file stage. It holds the architectural HI/LO registers and serves mfhi/mflo without using the ALU.

Parameters:
TIMEOUT_CYCLES, 64, max cycles in WAIT before forced abort; 0 disables the timeout.

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
instr_valid  in  1  instruction + operands valid
instr_ready  out  1  controller idle, accepts instruction
instr  in  32  MIPS instruction word
rs_data  in  32  value of $rs
rt_data  in  32  value of $rt
alu_en  out  1  ALU enable
alu_control  out  4  ADD=0 SUB=1 AND=2 OR=3 NOR=4 SLT=5 SLL=6 SRL=7 MULT=8 DIV=9
alu_srcA  out  32  rs_data, or zero-extended shamt for shifts
alu_srcB  out  32  rt_data or extended immediate
alu_result  in  32  ALU result
alu_hi, alu_lo  in  32 each  ALU HI/LO
alu_overflow  in  1  ALU overflow / divide-by-zero
alu_done  in  1  ALU completion
alu_zero  in  1  alu_result == 0
wb_valid  out  1  writeback record valid
wb_ready  in  1  consumer accepts record
wb_we  out  1  register write enable
wb_addr  out  5  destination register
wb_data  out  32  write data
wb_branch  out  1  record is beq/bne
wb_taken  out  1  branch taken
wb_ovf  out  1  signed overflow trap (write suppressed)
wb_div0  out  1  divide by zero
wb_illegal  out  1  unsupported instruction
wb_timeout  out  1  ALU did not finish within TIMEOUT_CYCLES

Behaviour:
- Reset (async): state IDLE; alu_en=0; alu_control=0; srcA/srcB=0; internal HI=LO=0; all wb_* = 0; instr_ready=1.
- States: IDLE, ISSUE, WAIT, WB.
- IDLE: instr_ready=1. On instr_valid, latch instr/operands and decode. ALU ops go to ISSUE; mfhi/mflo/illegal go directly to WB.
- ISSUE: one cycle. alu_control/srcA/srcB stable, alu_en=1, then go to WAIT.
- WAIT: alu_en=1. alu_done is ignored on the first WAIT cycle, because it can be stale from the previous op. It is sampled from the second WAIT cycle onward. On done: capture result and flags, drop alu_en, go to WB. The timeout counter counts WAIT cycles; reaching TIMEOUT_CYCLES gives WB with wb_timeout=1, wb_we=0, and HI/LO unchanged.
- WB: wb_valid=1 and all wb_* fields held stable until wb_ready=1, then go to IDLE. Minimum latency is 4 cycles from accept to wb_valid (ALU op with done on the 2nd WAIT cycle). mfhi/mflo take 1 cycle.
- Operands in alu_srcA/srcB are held constant from ISSUE through WAIT.
- R-type (op=0) funct map:
  - 20/21 add/addu → ADD; 22/23 sub/subu → SUB; 24 → AND; 25 → OR; 27 → NOR; 2A → SLT.
  - 00 sll → SLL; 02 srl → SRL. For both, srcA = {27'b0, shamt}.
  - 18 → MULT; 1A → DIV.
  - 10 mfhi and 12 mflo read internal HI/LO.
  - Destination is rd.
- I-type: 08 addi → ADD with sign-extended imm; 0A slti → SLT with sign-extended imm; 0C andi → AND with zero-extended imm; 0D ori → OR with zero-extended imm. Destination is rt.
- Branches: 04 beq and 05 bne → SUB of rs, rt. wb_branch=1, wb_we=0, wb_taken = alu_zero (beq) or !alu_zero (bne).
- wb_we=1 only for register-writing ops with dest≠0, no ovf, and no timeout.
- wb_ovf=alu_overflow only for add/sub/addi. It suppresses wb_we. It is ignored for addu/subu/logic ops.
- MULT: HI←alu_hi, LO←alu_lo on WAIT→WB; wb_we=0.
- DIV: same HI/LO capture; wb_div0=alu_overflow. A zero divisor still writes HI=LO=0.
- Any other opcode/funct: wb_illegal=1, wb_we=0, no ALU activity.
- instr_valid outside IDLE is ignored (not accepted).
- Reset mid-operation aborts immediately; no record is emitted.

Decomposition:
- Package alu_pkg: 4-bit ALU opcode constants, opcode/funct constants, state encoding.
- Sub-module alu_decode: purely combinational. Maps instr to alu_control, operand-select, dest, and class flags (write/branch/hilo/illegal/trap-on-ovf).

Test Plan:
1. add $3,$1,$2 with rs=5, rt=7; ALU returns 12, done → wb_we=1, wb_addr=3, wb_data=12, latency 4.
2. addi $4,$0,-1 (imm 0xFFFF) → alu_srcB=0xFFFFFFFF, alu_control=ADD; ALU returns 0xFFFFFFFF → wb_data=0xFFFFFFFF. Then add with alu_overflow=1 → wb_ovf=1, wb_we=0.
3. mult rs=0x10000, rt=0x10000; ALU hi=1, lo=0 → no write. Then mfhi $8 → wb_data=1 in 1 cycle; mflo $9 → 0.
4. div rt=0 with ALU overflow=1 → wb_div0=1; subsequent mflo returns 0.
5. beq rs=rt=9 with alu_zero=1 → wb_branch=1, wb_taken=1. Same operands as bne → wb_taken=0.
6. Mixed control cases:
   - Hold wb_ready=0 for 5 cycles: record stable and instr_ready=0.
   - Opcode 0x3F gives wb_illegal=1.
   - alu_done never asserted gives wb_timeout after 64 cycles.
   - rst pulsed during WAIT gives alu_en=0 and instr_ready=1 immediately.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared ALU opcodes, MIPS opcode/funct codes, controller state and decode record.
package alu_pkg;
   localparam logic [3:0] ALU_ADD = 4'd0, ALU_SUB = 4'd1, ALU_AND = 4'd2, ALU_OR = 4'd3, ALU_NOR = 4'd4;
   localparam logic [3:0] ALU_SLT = 4'd5, ALU_SLL = 4'd6, ALU_SRL = 4'd7, ALU_MULT = 4'd8, ALU_DIV = 4'd9;
   localparam logic [5:0] OP_RTYPE = 6'h00, OP_BEQ = 6'h04, OP_BNE = 6'h05, OP_ADDI = 6'h08;
   localparam logic [5:0] OP_SLTI = 6'h0A, OP_ANDI = 6'h0C, OP_ORI = 6'h0D;
   localparam logic [5:0] FN_SLL = 6'h00, FN_SRL = 6'h02, FN_MFHI = 6'h10, FN_MFLO = 6'h12;
   localparam logic [5:0] FN_MULT = 6'h18, FN_DIV = 6'h1A, FN_ADD = 6'h20, FN_ADDU = 6'h21;
   localparam logic [5:0] FN_SUB = 6'h22, FN_SUBU = 6'h23, FN_AND = 6'h24, FN_OR = 6'h25;
   localparam logic [5:0] FN_NOR = 6'h27, FN_SLT = 6'h2A;
   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_WB} state_t;
   typedef struct packed {
      logic [3:0] ctrl;
      logic       shamt_a;
      logic       imm_b;
      logic       imm_sext;
      logic [4:0] dest;
      logic       we;
      logic       branch;
      logic       bne;
      logic       trap;
      logic       hilo_wr;
      logic       is_div;
      logic       mfhi;
      logic       mflo;
      logic       illegal;
   } dec_t;
   function automatic logic [31:0] ext_imm(input logic [15:0] imm, input logic sext);
      return sext ? {{16{imm[15]}}, imm} : {16'b0, imm};
   endfunction
endpackage

// File: rtl/alu_decode.sv
// alu_decode: combinational MIPS instruction classifier feeding the execute sequencer.
module alu_decode
   import alu_pkg::*;
(
   input  logic [5:0] i_op,
   input  logic [5:0] i_funct,
   input  logic [4:0] i_rt,
   input  logic [4:0] i_rd,
   output dec_t       o_dec
);
   always_comb begin
      o_dec = '0;
      o_dec.dest = i_rt;
      case (i_op)
         OP_RTYPE: begin
            o_dec.dest = i_rd;
            o_dec.we = 1'b1;
            case (i_funct)
               FN_ADD:  begin o_dec.ctrl = ALU_ADD; o_dec.trap = 1'b1; end
               FN_ADDU: o_dec.ctrl = ALU_ADD;
               FN_SUB:  begin o_dec.ctrl = ALU_SUB; o_dec.trap = 1'b1; end
               FN_SUBU: o_dec.ctrl = ALU_SUB;
               FN_AND:  o_dec.ctrl = ALU_AND;
               FN_OR:   o_dec.ctrl = ALU_OR;
               FN_NOR:  o_dec.ctrl = ALU_NOR;
               FN_SLT:  o_dec.ctrl = ALU_SLT;
               FN_SLL:  begin o_dec.ctrl = ALU_SLL; o_dec.shamt_a = 1'b1; end
               FN_SRL:  begin o_dec.ctrl = ALU_SRL; o_dec.shamt_a = 1'b1; end
               FN_MULT: begin o_dec.ctrl = ALU_MULT; o_dec.we = 1'b0; o_dec.hilo_wr = 1'b1; end
               FN_DIV:  begin o_dec.ctrl = ALU_DIV; o_dec.we = 1'b0; o_dec.hilo_wr = 1'b1; o_dec.is_div = 1'b1; end
               FN_MFHI: o_dec.mfhi = 1'b1;
               FN_MFLO: o_dec.mflo = 1'b1;
               default: begin o_dec.we = 1'b0; o_dec.illegal = 1'b1; end
            endcase
         end
         OP_ADDI: begin o_dec.ctrl = ALU_ADD; o_dec.imm_b = 1'b1; o_dec.imm_sext = 1'b1; o_dec.we = 1'b1; o_dec.trap = 1'b1; end
         OP_SLTI: begin o_dec.ctrl = ALU_SLT; o_dec.imm_b = 1'b1; o_dec.imm_sext = 1'b1; o_dec.we = 1'b1; end
         OP_ANDI: begin o_dec.ctrl = ALU_AND; o_dec.imm_b = 1'b1; o_dec.we = 1'b1; end
         OP_ORI:  begin o_dec.ctrl = ALU_OR; o_dec.imm_b = 1'b1; o_dec.we = 1'b1; end
         OP_BEQ:  begin o_dec.ctrl = ALU_SUB; o_dec.branch = 1'b1; end
         OP_BNE:  begin o_dec.ctrl = ALU_SUB; o_dec.branch = 1'b1; o_dec.bne = 1'b1; end
         default: o_dec.illegal = 1'b1;
      endcase
   end
endmodule

// File: rtl/alu_exec_ctrl.sv
// alu_exec_ctrl: execute-stage sequencer driving a multicycle ALU and emitting one
// writeback/branch record per instruction; owns the architectural HI/LO registers.
module alu_exec_ctrl
   import alu_pkg::*;
#(
   parameter int unsigned TIMEOUT_CYCLES = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        instr_valid,
   output logic        instr_ready,
   input  logic [31:0] instr,
   input  logic [31:0] rs_data,
   input  logic [31:0] rt_data,
   output logic        alu_en,
   output logic [3:0]  alu_control,
   output logic [31:0] alu_srcA,
   output logic [31:0] alu_srcB,
   input  logic [31:0] alu_result,
   input  logic [31:0] alu_hi,
   input  logic [31:0] alu_lo,
   input  logic        alu_overflow,
   input  logic        alu_done,
   input  logic        alu_zero,
   output logic        wb_valid,
   input  logic        wb_ready,
   output logic        wb_we,
   output logic [4:0]  wb_addr,
   output logic [31:0] wb_data,
   output logic        wb_branch,
   output logic        wb_taken,
   output logic        wb_ovf,
   output logic        wb_div0,
   output logic        wb_illegal,
   output logic        wb_timeout
);
   state_t      r_state, w_next;
   dec_t        w_dec;
   logic        w_alu_op, w_done, w_tmo, w_accept, w_unused;
   logic [31:0] r_cnt, r_hi, r_lo;
   logic [4:0]  r_dest;
   logic        r_we, r_branch, r_bne, r_trap, r_hilo, r_div;

   assign w_unused = ^instr[25:21];

   alu_decode u_decode (
      .i_op    (instr[31:26]),
      .i_funct (instr[5:0]),
      .i_rt    (instr[20:16]),
      .i_rd    (instr[15:11]),
      .o_dec   (w_dec)
   );

   assign w_alu_op = !(w_dec.mfhi || w_dec.mflo || w_dec.illegal);
   assign w_accept = r_state == S_IDLE && instr_valid;
   // done on the first WAIT cycle may be left over from the previous op
   assign w_done = r_state == S_WAIT && r_cnt != 32'd0 && alu_done;
   assign w_tmo  = r_state == S_WAIT && TIMEOUT_CYCLES != 0 && r_cnt + 32'd1 == TIMEOUT_CYCLES && !w_done;

   always_ff @(posedge clk or posedge rst)
      if (rst) r_state <= S_IDLE;
      else     r_state <= w_next;

   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (instr_valid) w_next = w_alu_op ? S_ISSUE : S_WB;
         S_ISSUE: w_next = S_WAIT;
         S_WAIT:  if (w_done || w_tmo) w_next = S_WB;
         S_WB:    if (wb_ready) w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   always_comb begin
      instr_ready = r_state == S_IDLE;
      alu_en      = r_state == S_ISSUE || r_state == S_WAIT;
      wb_valid    = r_state == S_WB;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         alu_control <= '0;
         alu_srcA    <= '0;
         alu_srcB    <= '0;
         r_cnt       <= '0;
         r_hi        <= '0;
         r_lo        <= '0;
         r_dest      <= '0;
         {r_we, r_branch, r_bne, r_trap, r_hilo, r_div} <= '0;
         {wb_we, wb_addr, wb_data, wb_branch, wb_taken, wb_ovf, wb_div0, wb_illegal, wb_timeout} <= '0;
      end else begin
         if (w_accept) begin
            r_dest   <= w_dec.dest;
            r_we     <= w_dec.we && w_dec.dest != 5'd0;
            r_branch <= w_dec.branch;
            r_bne    <= w_dec.bne;
            r_trap   <= w_dec.trap;
            r_hilo   <= w_dec.hilo_wr;
            r_div    <= w_dec.is_div;
            r_cnt    <= '0;
            if (w_alu_op) begin
               alu_control <= w_dec.ctrl;
               alu_srcA    <= w_dec.shamt_a ? {27'b0, instr[10:6]} : rs_data;
               alu_srcB    <= w_dec.imm_b ? ext_imm(instr[15:0], w_dec.imm_sext) : rt_data;
            end else begin
               wb_we      <= w_dec.we && w_dec.dest != 5'd0;
               wb_addr    <= w_dec.dest;
               wb_data    <= w_dec.mfhi ? r_hi : r_lo;
               wb_branch  <= 1'b0;
               wb_taken   <= 1'b0;
               wb_ovf     <= 1'b0;
               wb_div0    <= 1'b0;
               wb_illegal <= w_dec.illegal;
               wb_timeout <= 1'b0;
            end
         end
         if (r_state == S_WAIT) r_cnt <= r_cnt + 32'd1;
         if (w_done || w_tmo) begin
            wb_addr    <= r_dest;
            wb_data    <= w_tmo ? 32'd0 : alu_result;
            wb_we      <= r_we && !w_tmo && !(r_trap && alu_overflow);
            wb_branch  <= r_branch && !w_tmo;
            wb_taken   <= r_branch && !w_tmo && (alu_zero ^ r_bne);
            wb_ovf     <= !w_tmo && r_trap && alu_overflow;
            wb_div0    <= !w_tmo && r_div && alu_overflow;
            wb_illegal <= 1'b0;
            wb_timeout <= w_tmo;
            // a zero divisor clears HI/LO whatever the ALU presents
            if (r_hilo && !w_tmo) begin
               r_hi <= (r_div && alu_overflow) ? 32'd0 : alu_hi;
               r_lo <= (r_div && alu_overflow) ? 32'd0 : alu_lo;
            end
         end
      end
   end
endmodule
